// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver / CPU side and the receive FIFO.
// The receiver strobes bytes in; the CPU side is a small 4-register window.
interface uart_rx_fifo_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       uart_cs;
    logic       R_W_n;
    logic [1:0] reg_addr;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       irq;

    // Handshake: a byte is transferred on every clock where rx_data_valid is
    // high; rx_data_ready is constant 1, so a full FIFO drops and flags overrun.
    modport master (
        output rx_data, rx_data_valid, uart_cs, R_W_n, reg_addr, data_i,
        input  rx_data_ready, data_o, irq
    );

    modport slave (
        input  rx_data, rx_data_valid, uart_cs, R_W_n, reg_addr, data_i,
        output rx_data_ready, data_o, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the CPU register window.
// Pops on the end of a data-register read; raises a level irq at a fill threshold.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_fifo_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic [3:0]            thr_q, thr_d;
    logic                  irq_q, irq_d;

    logic                  prev_cs_q, prev_cs_d;
    logic                  prev_rw_q, prev_rw_d;
    logic [1:0]            prev_addr_q, prev_addr_d;

    logic empty, full;
    logic cur_rd_data, prev_rd_data, rd_end;
    logic cur_wr, prev_wr_same, wr_start, ctrl_wr;
    logic flush, clr_ov, pop, push, overflow;
    logic ctrl_unused;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // An access is identified by (cs, R_W_n, addr); a change of any of these
    // ends the previous access, even without cs dropping.
    assign cur_rd_data  = bus.uart_cs & bus.R_W_n & (bus.reg_addr == ADDR_DATA);
    assign prev_rd_data = prev_cs_q & prev_rw_q & (prev_addr_q == ADDR_DATA);
    assign rd_end       = prev_rd_data & ~cur_rd_data;

    assign cur_wr       = bus.uart_cs & ~bus.R_W_n;
    assign prev_wr_same = prev_cs_q & ~prev_rw_q & (prev_addr_q == bus.reg_addr);
    assign wr_start     = cur_wr & ~prev_wr_same;
    assign ctrl_wr      = wr_start & (bus.reg_addr == ADDR_CTRL);

    assign flush    = ctrl_wr & bus.data_i[0];
    assign clr_ov   = ctrl_wr & bus.data_i[1];
    assign pop      = rd_end & ~empty;
    assign push     = bus.rx_data_valid & (~full | pop);
    assign overflow = bus.rx_data_valid & full & ~pop;

    assign ctrl_unused = ^bus.data_i[3:2];

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        thr_d     = thr_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end

        // A new overflow in the same cycle as a clear keeps overrun set.
        if (clr_ov)             overrun_d = 1'b0;
        if (overflow && !flush) overrun_d = 1'b1;

        if (ctrl_wr) thr_d = bus.data_i[7:4];

        irq_d = (thr_d != 4'd0) && (8'(count_d) >= {4'b0, thr_d});
    end

    assign prev_cs_d   = bus.uart_cs;
    assign prev_rw_d   = bus.R_W_n;
    assign prev_addr_d = bus.reg_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            thr_q       <= 4'd1;
            irq_q       <= 1'b0;
            prev_cs_q   <= 1'b0;
            prev_rw_q   <= 1'b0;
            prev_addr_q <= 2'd0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            thr_q       <= thr_d;
            irq_q       <= irq_d;
            prev_cs_q   <= prev_cs_d;
            prev_rw_q   <= prev_rw_d;
            prev_addr_q <= prev_addr_d;
        end
    end

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) mem_q[wr_ptr_q] <= bus.rx_data;
    end

    always_comb begin
        bus.data_o = 8'h00;
        case (bus.reg_addr)
            ADDR_DATA:   bus.data_o = empty ? 8'h00 : mem_q[rd_ptr_q];
            ADDR_STATUS: bus.data_o = {4'b0, irq_q, overrun_q, full, ~empty};
            ADDR_COUNT:  bus.data_o = 8'(count_q);
            ADDR_CTRL:   bus.data_o = {thr_q, 4'b0};
            default:     bus.data_o = 8'h00;
        endcase
    end

    assign bus.irq           = irq_q;
    assign bus.rx_data_ready = 1'b1;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for the main register
// behaviour, then hand-written sequences for the multi-cycle corner cases.
module tb_uart_rx_fifo;

    localparam int OP_PUSH  = 0;
    localparam int OP_READ  = 1;
    localparam int OP_WRITE = 2;
    localparam int OP_IRQ   = 3;

    typedef struct {
        int         op;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    uart_rx_fifo_if bus_if ();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic void add(input int op, input logic [1:0] addr,
                                input logic [7:0] data, input logic [7:0] exp,
                                input string name);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus_if.rx_data       = b;
        bus_if.rx_data_valid = 1'b1;
        tick();
        bus_if.rx_data_valid = 1'b0;
    endtask

    // Three-cycle read access, then one idle cycle (the pop edge for addr 0).
    task automatic read_reg(input logic [1:0] addr, output logic [7:0] first,
                            output logic [7:0] last);
        bus_if.uart_cs  = 1'b1;
        bus_if.R_W_n    = 1'b1;
        bus_if.reg_addr = addr;
        #1 first = bus_if.data_o;
        tick();
        tick();
        last = bus_if.data_o;
        tick();
        bus_if.uart_cs = 1'b0;
        tick();
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [7:0] d);
        bus_if.uart_cs  = 1'b1;
        bus_if.R_W_n    = 1'b0;
        bus_if.reg_addr = addr;
        bus_if.data_i   = d;
        tick();
        bus_if.uart_cs = 1'b0;
        bus_if.R_W_n   = 1'b1;
        tick();
    endtask

    task automatic read_check(input logic [1:0] addr, input logic [7:0] exp,
                              input string name);
        logic [7:0] f, l;
        read_reg(addr, f, l);
        check(name, f, exp);
        if (addr == 2'd0) check({name, "_stable"}, l, exp);
    endtask

    initial begin
        logic [7:0] f, l;
        total = 0;
        bad   = 0;

        // ---------------- vector table ----------------
        add(OP_READ, 2'd0, 8'h00, 8'h00, "rst_data");
        add(OP_READ, 2'd1, 8'h00, 8'h00, "rst_status");
        add(OP_READ, 2'd2, 8'h00, 8'h00, "rst_count");
        add(OP_READ, 2'd3, 8'h00, 8'h10, "rst_ctrl");
        add(OP_IRQ,  2'd0, 8'h00, 8'h00, "rst_irq");
        add(OP_PUSH, 2'd0, 8'h41, 8'h00, "");
        add(OP_PUSH, 2'd0, 8'h42, 8'h00, "");
        add(OP_PUSH, 2'd0, 8'h43, 8'h00, "");
        add(OP_IRQ,  2'd0, 8'h00, 8'h01, "irq_after3");
        add(OP_READ, 2'd2, 8'h00, 8'h03, "count3");
        add(OP_READ, 2'd1, 8'h00, 8'h09, "status3");
        add(OP_READ, 2'd0, 8'h00, 8'h41, "rd41");
        add(OP_READ, 2'd0, 8'h00, 8'h42, "rd42");
        add(OP_READ, 2'd0, 8'h00, 8'h43, "rd43");
        add(OP_READ, 2'd2, 8'h00, 8'h00, "count_drained");
        add(OP_READ, 2'd1, 8'h00, 8'h00, "status_drained");
        add(OP_IRQ,  2'd0, 8'h00, 8'h00, "irq_drained");
        for (int i = 0; i <= 16; i++) add(OP_PUSH, 2'd0, 8'(i), 8'h00, "");
        add(OP_READ, 2'd2, 8'h00, 8'h10, "count_full");
        add(OP_READ, 2'd1, 8'h00, 8'h0F, "status_full_ovr");
        add(OP_READ, 2'd0, 8'h00, 8'h00, "rd_empty_after_full_no");
        void'(vecs.pop_back());
        for (int i = 0; i < 16; i++)
            add(OP_READ, 2'd0, 8'h00, 8'(i), $sformatf("rd_full_%0d", i));
        add(OP_READ,  2'd1, 8'h00, 8'h04, "status_empty_ovr");
        add(OP_WRITE, 2'd3, 8'h12, 8'h00, "");
        add(OP_READ,  2'd1, 8'h00, 8'h00, "status_ovr_cleared");
        add(OP_READ,  2'd3, 8'h00, 8'h10, "thr_still_1");
        add(OP_READ,  2'd0, 8'h00, 8'h00, "rd_empty");

        bus_if.rx_data       = 8'h00;
        bus_if.rx_data_valid = 1'b0;
        bus_if.uart_cs       = 1'b0;
        bus_if.R_W_n         = 1'b1;
        bus_if.reg_addr      = 2'd0;
        bus_if.data_i        = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rx_data_ready", {7'b0, bus_if.rx_data_ready}, 8'h01);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_PUSH:  push(vecs[i].data);
                OP_WRITE: write_reg(vecs[i].addr, vecs[i].data);
                OP_IRQ:   check(vecs[i].name, {7'b0, bus_if.irq}, vecs[i].exp);
                default:  read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
            endcase
        end

        // ---------------- push and pop on the same edge while full ----------------
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        bus_if.uart_cs  = 1'b1;
        bus_if.R_W_n    = 1'b1;
        bus_if.reg_addr = 2'd0;
        #1 check("pp_head", bus_if.data_o, 8'h20);
        tick();
        tick();
        tick();
        bus_if.uart_cs       = 1'b0;
        bus_if.rx_data       = 8'hAA;
        bus_if.rx_data_valid = 1'b1;
        tick();
        bus_if.rx_data_valid = 1'b0;
        read_check(2'd2, 8'h10, "pp_count16");
        read_check(2'd1, 8'h0B, "pp_status_no_ovr");
        for (int i = 1; i < 16; i++) begin
            read_reg(2'd0, f, l);
            check($sformatf("pp_rd_%0d", i), f, 8'h20 + 8'(i));
        end
        read_check(2'd0, 8'hAA, "pp_rd_last_AA");
        read_check(2'd2, 8'h00, "pp_count0");

        // ---------------- threshold and flush-with-push ----------------
        write_reg(2'd3, 8'h40);
        read_check(2'd3, 8'h40, "thr4");
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("thr_irq_3", {7'b0, bus_if.irq}, 8'h00);
        push(8'h04);
        check("thr_irq_4", {7'b0, bus_if.irq}, 8'h01);
        bus_if.uart_cs       = 1'b1;
        bus_if.R_W_n         = 1'b0;
        bus_if.reg_addr      = 2'd3;
        bus_if.data_i        = 8'h01;
        bus_if.rx_data       = 8'h55;
        bus_if.rx_data_valid = 1'b1;
        tick();
        bus_if.rx_data_valid = 1'b0;
        bus_if.uart_cs       = 1'b0;
        bus_if.R_W_n         = 1'b1;
        check("flush_irq", {7'b0, bus_if.irq}, 8'h00);
        tick();
        read_check(2'd2, 8'h00, "flush_count");
        read_check(2'd1, 8'h00, "flush_status");
        read_check(2'd0, 8'h00, "flush_data");

        // ---------------- reset during a read with 5 bytes buffered ----------------
        write_reg(2'd3, 8'h10);
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        read_check(2'd2, 8'h05, "pre_rst_count");
        bus_if.uart_cs  = 1'b1;
        bus_if.R_W_n    = 1'b1;
        bus_if.reg_addr = 2'd0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus_if.uart_cs = 1'b0;
        tick();
        check("rst_irq_mid", {7'b0, bus_if.irq}, 8'h00);
        read_check(2'd2, 8'h00, "rst_mid_count");
        read_check(2'd3, 8'h10, "rst_mid_thr");
        push(8'h77);
        read_check(2'd2, 8'h01, "post_rst_count1");
        read_check(2'd0, 8'h77, "post_rst_rd77");
        read_check(2'd2, 8'h00, "post_rst_count0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
